// File: rtl/branch_predict_table.sv
// Dynamic branch predictor: 2-bit counter table + BTB, trained from BrOut.
// Ports: fetch lookup (F_*), execute update (E_*), Mispredict/Redirect_PC,
//   Ready after the init sweep, BrCount/MissCount statistics.
module branch_predict_table #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      F_PC,
    output logic             F_PredTaken,
    output logic [31:0]      F_PredTarget,
    output logic             Ready,
    input  logic             E_Valid,
    input  logic             E_IsBranch,
    input  logic [31:0]      E_PC,
    input  logic [31:0]      E_Target,
    input  logic             E_BrOut,
    input  logic             E_PredTaken,
    input  logic [31:0]      E_PredTarget,
    output logic             Mispredict,
    output logic [31:0]      Redirect_PC,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             sweep;
    logic             run;

    logic [1:0]       cnt_mem   [ENTRIES];
    logic             valid_mem [ENTRIES];
    logic [TAG_W-1:0] tag_mem   [ENTRIES];
    logic [31:0]      tgt_mem   [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic [1:0]       e_cnt;
    logic [1:0]       cnt_new;
    logic             upd;
    logic             unused;

    assign unused = ^{F_PC[1:0], E_PC[1:0]};

    // Init sweep / run state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sweep   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                sweep = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {IDX_W{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign run   = (state_q == S_RUN);
    assign Ready = run;

    // Fetch-side lookup; reads pre-update contents (no bypass)
    assign f_idx = F_PC[IDX_W+1:2];
    assign f_tag = F_PC[31:IDX_W+2];
    assign f_hit = run & valid_mem[f_idx] & (tag_mem[f_idx] == f_tag);

    assign F_PredTaken  = f_hit & cnt_mem[f_idx][1];
    assign F_PredTarget = F_PredTaken ? tgt_mem[f_idx] : F_PC + 32'd4;

    // Execute-side training
    assign upd   = run & E_Valid & E_IsBranch;
    assign e_idx = E_PC[IDX_W+1:2];
    assign e_tag = E_PC[31:IDX_W+2];
    assign e_hit = valid_mem[e_idx] & (tag_mem[e_idx] == e_tag);
    assign e_cnt = cnt_mem[e_idx];

    // A taken branch that does not own the entry replaces it at weak-taken
    always_comb begin
        cnt_new = e_cnt;
        if (E_BrOut) begin
            if (!e_hit) begin
                cnt_new = 2'b10;
            end else if (e_cnt != 2'b11) begin
                cnt_new = e_cnt + 2'b01;
            end
        end else if (e_cnt != 2'b00) begin
            cnt_new = e_cnt - 2'b01;
        end
    end

    // Table storage has no reset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (sweep) begin
            cnt_mem[ptr_q]   <= 2'b01;
            valid_mem[ptr_q] <= 1'b0;
        end else if (upd) begin
            cnt_mem[e_idx] <= cnt_new;
            if (E_BrOut) begin
                valid_mem[e_idx] <= 1'b1;
                tag_mem[e_idx]   <= e_tag;
                tgt_mem[e_idx]   <= E_Target;
            end
        end
    end

    assign Mispredict = upd &
        ((E_BrOut != E_PredTaken) |
         (E_BrOut & E_PredTaken & (E_PredTarget != E_Target)));

    assign Redirect_PC = E_BrOut ? E_Target : E_PC + 32'd4;

    // Saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BrCount   <= '0;
            MissCount <= '0;
        end else if (upd) begin
            if (BrCount != {CNT_W{1'b1}}) begin
                BrCount <= BrCount + 1'b1;
            end
            if (Mispredict && (MissCount != {CNT_W{1'b1}})) begin
                MissCount <= MissCount + 1'b1;
            end
        end
    end

endmodule
